l1_fill_responder: RTL and testbench
====================================

# l1_fill_responder

Memory-side responder for the L1 cache miss interface: accepts the cache's `I_req`/`I_addr`/`I_write` request, serves a 4-word line fill or a single masked write from a synchronous single-port SRAM, and paces the cache with `I_wait`. It sits between a cache's memory port and a local SRAM macro wrapper. It is used as the backing store in cache unit benches and in the memory-side half of the CPU wrapper. It is the responder for the burst protocol the L1 caches initiate.

## Interface
- `MEM_AW`, 14: SRAM word-address width.
- `FIRST_LAT`, 2: idle `I_wait=1` cycles between request acceptance and the first SRAM read issue. Legal range is 0..15.

- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `I_req`  in  1  cache request.
- `I_addr`  in  32  byte address. Line-aligned for fills.
- `I_write`  in  1  1 = write, 0 = line fill.
- `I_in`  in  32  write data, right-aligned.
- `I_type`  in  3  access size: 3'b000 byte, 3'b001 halfword, 3'b010 word, 3'b100 byte unsigned, 3'b101 halfword unsigned.
- `I_out`  out  32  fill beat data.
- `I_wait`  out  1  0 marks a beat (read) or an ack (write).
- `mem_cs`  out  1  SRAM chip select.
- `mem_oe`  out  1  SRAM output enable.
- `mem_web`  out  4  per-byte write enable, active-low.
- `mem_a`  out  `MEM_AW`  SRAM word address.
- `mem_di`  out  32  SRAM write data.
- `mem_do`  in  32  SRAM read data, valid the cycle after a read is issued.

## Operation
- States and transitions:
  - IDLE: read request → LAT, or → ISSUE directly when `FIRST_LAT`=0. Write request → WR.
  - LAT → ISSUE.
  - ISSUE → RD.
  - RD → RD / GAP / DONE.
  - GAP → RD.
  - WR → DONE.
  - DONE → IDLE.
- Acceptance happens only in IDLE on `I_req`=1. At acceptance the block latches `I_addr`, `I_write`, `I_in` and `I_type`. In every state other than IDLE, `I_req` and all other inputs are ignored.
- Line base is latched `I_addr[31:4]`. For beat k (0..3), `mem_a` = {latched `I_addr[MEM_AW+1:4]`, k[1:0]}. Address bits above `MEM_AW+1` are dropped.
- LAT: a counter loaded with `FIRST_LAT` counts down to 1. `I_wait`=1 throughout.
- ISSUE: read of beat 0 is issued (`mem_cs`=1, `mem_oe`=1, `mem_web`=4'hF).
- RD: `I_out`=`mem_do`, `I_wait`=0. The 2-bit beat counter increments. The read for beat k+1 is issued in the same cycle (without `FILL_BEAT_GAP_EN`). After beat 3, go to DONE.
- WR:
  - Issue the SRAM write with `mem_web` derived from latched size and `I_addr[1:0]`.
  - Byte: lane `addr[1:0]`, data replicated into all lanes.
  - Halfword: lanes {1,0} or {3,2} selected by `addr[1]`; `addr[0]` is ignored.
  - Word: 4'h0; `addr[1:0]` are ignored.
  - `I_wait`=0 this cycle as the ack.
- DONE: `I_wait`=1, no SRAM access. This state guarantees that a lingering `I_req` is not re-accepted.
- Outside beat cycles, `I_out` is 0. Outside access cycles, `mem_cs`=`mem_oe`=0 and `mem_web`=4'hF.
- There is no abort. If `I_req` drops mid-burst, the burst still completes all 4 beats.
- Reset state (asserted at any time, including mid-burst):
  - State IDLE, counters 0.
  - `I_wait`=1, `I_out`=0.
  - `mem_cs`=0, `mem_oe`=0, `mem_web`=4'hF, `mem_a`=0, `mem_di`=0.
  - An in-flight write issued in the reset cycle is not guaranteed to land.

## Timing
- Read accepted at cycle T: ISSUE at T+1+`FIRST_LAT`; beats 0..3 at T+2+`FIRST_LAT` .. T+5+`FIRST_LAT`; DONE at T+6+`FIRST_LAT`; IDLE at T+7+`FIRST_LAT`.
- Write accepted at T: ack at T+1, DONE at T+2, next acceptance possible at T+3.
- Exactly 4 cycles with `I_wait`=0 per fill and exactly 1 per write.

## Configuration
- `FILL_BEAT_GAP_EN` defined:
  - A GAP cycle (`I_wait`=1, `I_out`=0) is inserted after beats 0, 1 and 2.
  - The read for the next beat is issued in GAP, not in RD.
  - Beats land at T+2+F, T+4+F, T+6+F, T+8+F, where F = `FIRST_LAT`; DONE at T+9+F.
  - Purpose: exercises the cache's beat counting on non-consecutive beats.
- `FILL_BEAT_GAP_EN` undefined: no GAP state, and beats are back-to-back.

## Test plan
- Fill: preload words 0x100..0x10C with 0xA0..0xA3, `FIRST_LAT`=2, read at 0x100 accepted at T → beats A0,A1,A2,A3 with `I_wait`=0 at T+4..T+7, otherwise `I_wait`=1.
- Lingering req: hold `I_req`=1 for 3 cycles after beat 3 → no second burst; next acceptance exactly at T+9.
- Writes:
  - Byte: addr 0x203, `I_in`=0x5A → `mem_web`=4'b0111, word reads 0x5A in byte 3, ack at T+1.
  - Halfword: addr 0x206, `I_in`=0xBEEF → `mem_web`=4'b0011.
- Reset: drive `rstn`=0 during beat 2 → `I_wait`=1, `I_out`=0, `mem_cs`=0 immediately. After release, a new fill returns the full 4 beats.
- `FILL_BEAT_GAP_EN`, `FIRST_LAT`=0: read accepted at T → beats at T+2, T+4, T+6, T+8 and `I_wait`=1 at T+3, T+5, T+7.

Source files
------------

// File: rtl/l1_fill_responder_if.sv
// Bundle between an L1 cache memory port, the fill responder and the SRAM macro.
// slave  : the responder's view (takes cache requests and SRAM read data,
//          drives beats/acks and the SRAM control pins).
// master : the environment's view (cache plus SRAM macro).
interface l1_fill_responder_if #(
    parameter int MEM_AW = 14
);
    logic              I_req;
    logic [31:0]       I_addr;
    logic              I_write;
    logic [31:0]       I_in;
    logic [2:0]        I_type;
    logic [31:0]       I_out;
    logic              I_wait;
    logic              mem_cs;
    logic              mem_oe;
    logic [3:0]        mem_web;
    logic [MEM_AW-1:0] mem_a;
    logic [31:0]       mem_di;
    logic [31:0]       mem_do;

    modport slave (
        input  I_req, I_addr, I_write, I_in, I_type, mem_do,
        output I_out, I_wait, mem_cs, mem_oe, mem_web, mem_a, mem_di
    );

    modport master (
        output I_req, I_addr, I_write, I_in, I_type, mem_do,
        input  I_out, I_wait, mem_cs, mem_oe, mem_web, mem_a, mem_di
    );
endinterface

// File: rtl/l1_fill_responder.sv
// l1_fill_responder: serves 4-word line fills and single masked writes from a
// synchronous single-port SRAM, pacing the cache with I_wait.
// Optional feature: define FILL_BEAT_GAP_EN to insert one idle GAP cycle
// between consecutive fill beats (next read issued in GAP instead of RD).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for I_req; the only state that accepts a request
// LAT   | first-access latency countdown, I_wait=1
// ISSUE | read of beat 0 issued
// RD    | beat presented (I_wait=0); next read issued unless gapped
// GAP   | (FILL_BEAT_GAP_EN) no beat; read of the next beat issued
// WR    | masked SRAM write issued, I_wait=0 as the ack
// DONE  | one dead cycle so a lingering I_req is not re-accepted
module l1_fill_responder #(
    parameter int MEM_AW    = 14,
    parameter int FIRST_LAT = 2
) (
    input  logic               clk,
    input  logic               rstn,
    l1_fill_responder_if.slave bus
);

`ifdef FILL_BEAT_GAP_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LAT   = 3'd1,
        S_ISSUE = 3'd2,
        S_RD    = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5,
        S_GAP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LAT   = 3'd1,
        S_ISSUE = 3'd2,
        S_RD    = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [MEM_AW+1:0]   addr_q, addr_d;
    logic [2:0]          type_q, type_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          lat_q, lat_d;
    logic [1:0]          beat_q, beat_d;

    logic [31:0]         i_out;
    logic                i_wait;
    logic                mem_cs;
    logic                mem_oe;
    logic [3:0]          mem_web;
    logic [MEM_AW-1:0]   mem_a;
    logic [31:0]         mem_di;
    logic [1:0]          rd_beat;
    logic [3:0]          wr_web;
    logic [31:0]         wr_data;

    // Address bits above the SRAM window are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.I_addr[31:MEM_AW+2];

    // State and request-latch registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic; inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.I_req) begin
                    addr_d  = bus.I_addr[MEM_AW+1:0];
                    type_d  = bus.I_type;
                    wdata_d = bus.I_in;
                    beat_d  = 2'd0;
                    if (bus.I_write) begin
                        state_d = S_WR;
                    end else if (FIRST_LAT == 0) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_LAT;
                        lat_d   = 4'(FIRST_LAT);
                    end
                end
            end
            S_LAT: begin
                if (lat_q <= 4'd1) begin
                    state_d = S_ISSUE;
                    lat_d   = 4'd0;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_ISSUE: state_d = S_RD;
            S_RD: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
`ifdef FILL_BEAT_GAP_EN
                    state_d = S_GAP;
`else
                    state_d = S_RD;
`endif
                end
            end
`ifdef FILL_BEAT_GAP_EN
            S_GAP:   state_d = S_RD;
`endif
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Byte-lane mask and lane-replicated data for the latched write size.
    // Unlisted size codes write nothing but still get acked.
    always_comb begin
        wr_web  = 4'hF;
        wr_data = wdata_q;
        case (type_q)
            3'b000, 3'b100: begin
                wr_web  = ~(4'b0001 << addr_q[1:0]);
                wr_data = {4{wdata_q[7:0]}};
            end
            3'b001, 3'b101: begin
                wr_web  = addr_q[1] ? 4'b0011 : 4'b1100;
                wr_data = {2{wdata_q[15:0]}};
            end
            3'b010:  wr_web = 4'h0;
            default: wr_web = 4'hF;
        endcase
    end

    // Cache-side and SRAM-side outputs decoded from the current state.
    always_comb begin
        i_out   = 32'h0;
        i_wait  = 1'b1;
        mem_cs  = 1'b0;
        mem_oe  = 1'b0;
        mem_web = 4'hF;
        mem_a   = '0;
        mem_di  = 32'h0;
        rd_beat = beat_q;
        case (state_q)
            S_ISSUE: begin
                rd_beat = 2'd0;
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                mem_a   = {addr_q[MEM_AW+1:4], rd_beat};
            end
            S_RD: begin
                i_out  = bus.mem_do;
                i_wait = 1'b0;
`ifndef FILL_BEAT_GAP_EN
                if (beat_q != 2'd3) begin
                    rd_beat = beat_q + 2'd1;
                    mem_cs  = 1'b1;
                    mem_oe  = 1'b1;
                    mem_a   = {addr_q[MEM_AW+1:4], rd_beat};
                end
`endif
            end
`ifdef FILL_BEAT_GAP_EN
            S_GAP: begin
                rd_beat = beat_q;
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                mem_a   = {addr_q[MEM_AW+1:4], rd_beat};
            end
`endif
            S_WR: begin
                i_wait  = 1'b0;
                mem_cs  = 1'b1;
                mem_web = wr_web;
                mem_a   = addr_q[MEM_AW+1:2];
                mem_di  = wr_data;
            end
            default: begin
                i_wait = 1'b1;
            end
        endcase
    end

    assign bus.I_out   = i_out;
    assign bus.I_wait  = i_wait;
    assign bus.mem_cs  = mem_cs;
    assign bus.mem_oe  = mem_oe;
    assign bus.mem_web = mem_web;
    assign bus.mem_a   = mem_a;
    assign bus.mem_di  = mem_di;

endmodule

// File: tb/tb_l1_fill_responder.sv
// Directed bench for l1_fill_responder with a behavioural synchronous SRAM.
module tb_l1_fill_responder;
    localparam int AW = 14;
`ifdef FILL_BEAT_GAP_EN
    localparam int F           = 0;
    localparam int LAST_BEAT_C = 8 + F;
`else
    localparam int F           = 2;
    localparam int LAST_BEAT_C = 5 + F;
`endif
    localparam int DONE_C = LAST_BEAT_C + 1;
    localparam int ACC2   = DONE_C + 1;

    logic clk;
    logic rstn;
    int   nchk  = 0;
    int   npass = 0;
    logic [31:0] sram [0:(1<<AW)-1];

    l1_fill_responder_if #(.MEM_AW(AW)) bus();

    l1_fill_responder #(.MEM_AW(AW), .FIRST_LAT(F)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read data appears the cycle after the read is issued.
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_oe) bus.mem_do <= sram[bus.mem_a];
            for (int i = 0; i < 4; i++)
                if (!bus.mem_web[i]) sram[bus.mem_a][8*i +: 8] = bus.mem_di[8*i +: 8];
        end
    end

    // Beat index presented at cycle T+c after acceptance, or -1.
    function automatic int beat_of(input int c);
        int r;
        r = c - (2 + F);
`ifdef FILL_BEAT_GAP_EN
        if (r >= 0 && r <= 6 && (r % 2) == 0) return r / 2;
`else
        if (r >= 0 && r <= 3) return r;
`endif
        return -1;
    endfunction

    task automatic test_reset();
        nchk++; if (bus.I_wait !== 1'b1) $display("FAIL reset_wait got=%b exp=1", bus.I_wait); else npass++;
        nchk++; if (bus.I_out !== 32'h0) $display("FAIL reset_out got=%h exp=0", bus.I_out); else npass++;
        nchk++; if (bus.mem_cs !== 1'b0 || bus.mem_oe !== 1'b0)
            $display("FAIL reset_cs_oe got=%b%b exp=00", bus.mem_cs, bus.mem_oe); else npass++;
        nchk++; if (bus.mem_web !== 4'hF) $display("FAIL reset_web got=%h exp=f", bus.mem_web); else npass++;
        nchk++; if (bus.mem_a !== 14'h0 || bus.mem_di !== 32'h0)
            $display("FAIL reset_a_di got=%h/%h exp=0/0", bus.mem_a, bus.mem_di); else npass++;
    endtask

    task automatic fill_and_check(input string tag, input logic [31:0] addr,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0]   exp_d [4];
        logic [AW-1:0] exp_a;
        int            b;
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        exp_a = {addr[AW+1:4], 2'b00};
        @(negedge clk);
        nchk++; if (bus.I_wait !== 1'b1) $display("FAIL %s idle_wait got=%b exp=1", tag, bus.I_wait); else npass++;
        bus.I_req = 1'b1; bus.I_write = 1'b0; bus.I_addr = addr; bus.I_type = 3'b010; bus.I_in = 32'h0;
        for (int c = 1; c <= DONE_C; c++) begin
            @(negedge clk);
            if (c == 1) bus.I_req = 1'b0;
            b = beat_of(c);
            nchk++;
            if (b >= 0) begin
                if (bus.I_wait !== 1'b0 || bus.I_out !== exp_d[b])
                    $display("FAIL %s beat%0d c=%0d wait=%b out=%h exp_wait=0 exp_out=%h", tag, b, c, bus.I_wait, bus.I_out, exp_d[b]);
                else npass++;
            end else begin
                if (bus.I_wait !== 1'b1 || bus.I_out !== 32'h0)
                    $display("FAIL %s idle c=%0d wait=%b out=%h exp_wait=1 exp_out=0", tag, c, bus.I_wait, bus.I_out);
                else npass++;
            end
            if (c == 1 + F) begin
                nchk++;
                if (bus.mem_cs !== 1'b1 || bus.mem_oe !== 1'b1 || bus.mem_web !== 4'hF || bus.mem_a !== exp_a)
                    $display("FAIL %s issue cs=%b oe=%b web=%h a=%h exp 1 1 f %h", tag, bus.mem_cs, bus.mem_oe, bus.mem_web, bus.mem_a, exp_a);
                else npass++;
            end
        end
    endtask

    task automatic test_fill();
        fill_and_check("fill", 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    endtask

    task automatic test_lingering();
        logic [31:0] exp_d [4];
        logic        exp_w;
        logic [31:0] exp_o;
        int          b;
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
        @(negedge clk);
        bus.I_req = 1'b1; bus.I_write = 1'b0; bus.I_addr = 32'h100;
        for (int c = 1; c <= ACC2 + DONE_C; c++) begin
            @(negedge clk);
            if (c == ACC2 + 1) bus.I_req = 1'b0;
            if (c <= DONE_C)    b = beat_of(c);
            else if (c > ACC2)  b = beat_of(c - ACC2);
            else                b = -1;
            exp_w = (b < 0);
            exp_o = (b < 0) ? 32'h0 : exp_d[b];
            nchk++;
            if (bus.I_wait !== exp_w || bus.I_out !== exp_o)
                $display("FAIL linger c=%0d wait=%b out=%h exp_wait=%b exp_out=%h", c, bus.I_wait, bus.I_out, exp_w, exp_o);
            else npass++;
        end
    endtask

    task automatic test_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] typ, input logic [3:0] exp_web,
                              input logic [31:0] exp_di, input logic [31:0] exp_word);
        logic [AW-1:0] widx;
        widx = addr[AW+1:2];
        @(negedge clk);
        bus.I_req = 1'b1; bus.I_write = 1'b1; bus.I_addr = addr; bus.I_in = data; bus.I_type = typ;
        @(negedge clk);
        bus.I_req = 1'b0;
        nchk++;
        if (bus.I_wait !== 1'b0 || bus.mem_cs !== 1'b1 || bus.mem_oe !== 1'b0 ||
            bus.mem_web !== exp_web || bus.mem_di !== exp_di || bus.mem_a !== widx)
            $display("FAIL %s ack wait=%b cs=%b oe=%b web=%b di=%h a=%h exp 0 1 0 %b %h %h",
                     tag, bus.I_wait, bus.mem_cs, bus.mem_oe, bus.mem_web, bus.mem_di, bus.mem_a, exp_web, exp_di, widx);
        else npass++;
        @(negedge clk);
        nchk++;
        if (bus.I_wait !== 1'b1 || bus.mem_cs !== 1'b0 || bus.mem_web !== 4'hF)
            $display("FAIL %s done wait=%b cs=%b web=%h exp 1 0 f", tag, bus.I_wait, bus.mem_cs, bus.mem_web);
        else npass++;
        nchk++;
        if (sram[widx] !== exp_word) $display("FAIL %s word got=%h exp=%h", tag, sram[widx], exp_word); else npass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.I_req = 1'b1; bus.I_write = 1'b1; bus.I_addr = 32'h20B; bus.I_in = 32'hCAFEF00D; bus.I_type = 3'b010;
        @(negedge clk);
        nchk++;
        if (bus.I_wait !== 1'b0 || bus.mem_web !== 4'h0 || bus.mem_di !== 32'hCAFEF00D || bus.mem_a !== 14'h82)
            $display("FAIL b2b ack1 wait=%b web=%b di=%h a=%h exp 0 0000 cafef00d 82", bus.I_wait, bus.mem_web, bus.mem_di, bus.mem_a);
        else npass++;
        bus.I_addr = 32'h20D; bus.I_in = 32'h777; bus.I_type = 3'b100;
        @(negedge clk);
        nchk++; if (bus.I_wait !== 1'b1 || bus.mem_cs !== 1'b0)
            $display("FAIL b2b done1 wait=%b cs=%b exp 1 0", bus.I_wait, bus.mem_cs); else npass++;
        @(negedge clk);
        nchk++; if (bus.I_wait !== 1'b1 || bus.mem_cs !== 1'b0)
            $display("FAIL b2b idle wait=%b cs=%b exp 1 0", bus.I_wait, bus.mem_cs); else npass++;
        @(negedge clk);
        bus.I_req = 1'b0;
        nchk++;
        if (bus.I_wait !== 1'b0 || bus.mem_web !== 4'b1101 || bus.mem_di !== 32'h77777777 || bus.mem_a !== 14'h83)
            $display("FAIL b2b ack2 wait=%b web=%b di=%h a=%h exp 0 1101 77777777 83", bus.I_wait, bus.mem_web, bus.mem_di, bus.mem_a);
        else npass++;
        @(negedge clk);
        nchk++; if (bus.I_wait !== 1'b1) $display("FAIL b2b done2 wait=%b exp=1", bus.I_wait); else npass++;
        nchk++; if (sram[14'h82] !== 32'hCAFEF00D) $display("FAIL b2b word82 got=%h exp=cafef00d", sram[14'h82]); else npass++;
        nchk++; if (sram[14'h83] !== 32'h00007700) $display("FAIL b2b word83 got=%h exp=00007700", sram[14'h83]); else npass++;
    endtask

    task automatic test_readback();
        fill_and_check("readback", 32'h200, 32'h5A223344, 32'hBEEF4567, 32'hCAFEF00D, 32'h00007700);
    endtask

    task automatic test_reset_midburst();
        logic hit;
        hit = 1'b0;
        @(negedge clk);
        bus.I_req = 1'b1; bus.I_write = 1'b0; bus.I_addr = 32'h100;
        for (int c = 1; c <= DONE_C; c++) begin
            @(negedge clk);
            if (c == 1) bus.I_req = 1'b0;
            if (beat_of(c) == 2) begin
                hit = 1'b1;
                nchk++;
                if (bus.I_wait !== 1'b0 || bus.I_out !== 32'hA2)
                    $display("FAIL rst_beat2 wait=%b out=%h exp 0 a2", bus.I_wait, bus.I_out);
                else npass++;
                rstn = 1'b0;
                #1;
                nchk++;
                if (bus.I_wait !== 1'b1 || bus.I_out !== 32'h0 || bus.mem_cs !== 1'b0)
                    $display("FAIL rst_async wait=%b out=%h cs=%b exp 1 0 0", bus.I_wait, bus.I_out, bus.mem_cs);
                else npass++;
                break;
            end
        end
        nchk++; if (hit !== 1'b1) $display("FAIL rst_reach_beat2 got=%b exp=1", hit); else npass++;
        rstn = 1'b0;
        @(negedge clk);
        nchk++;
        if (bus.I_wait !== 1'b1 || bus.mem_a !== 14'h0 || bus.mem_web !== 4'hF)
            $display("FAIL rst_hold wait=%b a=%h web=%h exp 1 0 f", bus.I_wait, bus.mem_a, bus.mem_web);
        else npass++;
        rstn = 1'b1;
        fill_and_check("post_reset", 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    endtask

    initial begin
        rstn = 1'b0;
        bus.I_req = 1'b0; bus.I_addr = 32'h0; bus.I_write = 1'b0; bus.I_in = 32'h0; bus.I_type = 3'b010;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'h0;
        sram[14'h40] = 32'hA0; sram[14'h41] = 32'hA1; sram[14'h42] = 32'hA2; sram[14'h43] = 32'hA3;
        sram[14'h80] = 32'h11223344; sram[14'h81] = 32'h01234567;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        test_fill();
        test_lingering();
        test_write("wr_byte", 32'h203, 32'h5A, 3'b000, 4'b0111, 32'h5A5A5A5A, 32'h5A223344);
        test_write("wr_half", 32'h206, 32'hBEEF, 3'b001, 4'b0011, 32'hBEEFBEEF, 32'hBEEF4567);
        test_back_to_back();
        test_readback();
        test_reset_midburst();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
